serial_shift_arbiter: RTL and testbench
=======================================

# serial_shift_arbiter

Two-requester front end for the serial shift path. It arbitrates round-robin between two parallel-word sources and loads the granted word into an internal parallel-in/serial-out shift register. It then sequences exactly WIDTH shift cycles, MSB first, onto a single serial line. It sits upstream of the serial-in/serial-out delay stage and is the only driver of that stage's serial input.

## Interface
- WIDTH, 4, bits per frame; legal range 2..32
- CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridable)

- clk  in  1  rising-edge clock; the block uses this clock only
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  bit i means requester i has a word pending
- req_data0  in  WIDTH  requester 0 word; must be stable while req_valid[0] is high
- req_data1  in  WIDTH  requester 1 word; must be stable while req_valid[1] is high
- req_ready  out  2  one-hot or zero; bit i high means requester i's word is taken this cycle
- serial_out  out  1  serial bit stream, MSB first; 0 when not shifting
- frame_active  out  1  high on every cycle serial_out carries a frame bit
- frame_last  out  1  high on the cycle serial_out carries the LSB
- grant_id  out  1  owner of the current or most recent frame

## Operation
- States: IDLE and SHIFT.
- Reset forces the following values:
  - state = IDLE, serial_out = 0, frame_active = 0, frame_last = 0.
  - req_ready = 00, grant_id = 0, round-robin pointer = 0 (requester 0 preferred).
- Arbitration in IDLE (combinational):
  - One valid requester: that requester wins.
  - Both valid: the requester the pointer designates wins.
  - req_ready[winner] = 1 in the same cycle. A transfer occurs when req_valid[i] && req_ready[i].
  - req_ready is 00 in SHIFT and whenever req_valid = 00.
- On a transfer at edge T:
  - The shift register loads the winner's data.
  - The bit counter loads WIDTH-1.
  - grant_id = winner, and the pointer moves to the other requester.
  - state becomes SHIFT.
- In SHIFT:
  - serial_out = shreg[WIDTH-1] and frame_active = 1.
  - Each edge shifts the register left with 0 fill and decrements the counter.
  - frame_last = 1 when the counter is 0. At that edge state returns to IDLE.
- The pointer changes only on a transfer. A lone requester never moves it past the other requester's turn incorrectly: after granting i, the pointer always names 1-i.
- Words are never dropped or duplicated. A requester that drops req_valid before its handshake has issued no request.

## Timing
- All outputs are registered, except req_ready, which is combinational from state, req_valid and the pointer.
- A handshake in cycle T (sampled at edge T) produces:
  - MSB on serial_out during cycle T+1.
  - LSB during cycle T+WIDTH, with frame_last = 1.
  - IDLE again in cycle T+WIDTH+1.
- The earliest next handshake is cycle T+WIDTH+1. Frames are separated by exactly one cycle with serial_out = 0 (frame period WIDTH+1).
- Throughput under saturating requests is one frame per WIDTH+1 cycles, alternating 0,1,0,1.
- Reset asserted mid-frame:
  - The frame is aborted at the next edge and serial_out = 0 from then on.
  - No frame_last is produced.
  - The partial frame is not retried.
- When rst and req_valid are high in the same cycle, reset wins: req_ready = 00 and no transfer occurs.

## Structure
- Shared package `serial_pkg`:
  - State enum {S_IDLE, S_SHIFT}.
  - Default WIDTH constant, so the downstream delay stage and this block agree on frame size.
- One sub-module, `piso_shreg`: a WIDTH-bit parallel-load, shift-left, serial-out register with load/shift enables and synchronous active-high rst.
- The top level holds the FSM, the counter, the round-robin pointer and the req_ready logic.

## Test plan
- Reset then single request: after rst, req_valid = 01 with req_data0 = 4'b1011 → req_ready = 01 for one cycle; serial_out = 1,0,1,1 in the next 4 cycles; frame_last on the 4th; grant_id = 0.
- Contention: req_valid = 11 from reset with data0 = 4'hA and data1 = 4'h5 → frame A with grant 0, one idle cycle, then frame 5 with grant 1; alternation continues while both are held.
- Lone requester repeat: only req_valid[1] held with data 4'hF → back-to-back frames every 5 cycles; all frames use grant_id = 1; serial_out is 0 only in the gap cycles.
- Back-pressure: raise req_valid[0] mid-frame → req_ready stays 00 until the first IDLE cycle; handshake in cycle T+WIDTH+1.
- Mid-frame reset: assert rst after the 2nd bit of 4'b1100 → serial_out = 0 and frame_active = 0 the next cycle, no frame_last, pointer back to 0 (the next 11 contention grants requester 0).
- WIDTH = 8 build: data 8'h81 → serial_out 1,0,0,0,0,0,0,1; frame period 9 cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM states and default frame width for the serial shift path
package serial_pkg;
    typedef enum logic {S_IDLE, S_SHIFT} state_t;
    localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: parallel-load, shift-left, zero-fill register presenting its MSB serially
module piso_shreg
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_msb
);
    logic [WIDTH-1:0] q;
    // load wins over shift; zero fill leaves the register empty once a frame is out
    always_ff @(posedge clk) begin
        if (rst)        q <= '0;
        else if (load)  q <= d;
        else if (shift) q <= {q[WIDTH-2:0], 1'b0};
    end
    assign q_msb = q[WIDTH-1];
endmodule

// File: rtl/serial_shift_arbiter.sv
// serial_shift_arbiter: round-robin two-requester front end that serializes granted words MSB first
module serial_shift_arbiter
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    output logic [1:0]       req_ready,
    output logic             serial_out,
    output logic             frame_active,
    output logic             frame_last,
    output logic             grant_id
);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             ptr;
    logic             winner;
    logic             xfer;
    logic             shifting;
    assign winner   = (req_valid == 2'b11) ? ptr : req_valid[1];
    assign xfer     = |req_ready;
    assign shifting = state == S_SHIFT;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end
    // leave IDLE on a handshake, return after the bit with counter 0
    always_comb begin
        state_nx = state;
        if (state == S_IDLE) state_nx = xfer ? S_SHIFT : S_IDLE;
        else                 state_nx = (cnt == '0) ? S_IDLE : S_SHIFT;
    end
    // grant only in IDLE and never while reset is asserted
    always_comb begin
        req_ready    = (state == S_IDLE && !rst && |req_valid) ? (winner ? 2'b10 : 2'b01) : 2'b00;
        frame_active = shifting;
        frame_last   = shifting && cnt == '0;
    end
    // bit counter, owner of the frame and round-robin pointer (flips to the loser on every grant)
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            ptr      <= 1'b0;
            grant_id <= 1'b0;
        end else if (xfer) begin
            cnt      <= CNT_W'(WIDTH - 1);
            ptr      <= ~winner;
            grant_id <= winner;
        end else if (shifting) begin
            cnt      <= cnt - 1'b1;
        end
    end
    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (xfer),
        .shift (shifting),
        .d     (winner ? req_data1 : req_data0),
        .q_msb (serial_out)
    );
endmodule

// File: tb/tb_serial_shift_arbiter.sv
// tb_serial_shift_arbiter: randomized and directed checks against a queue-based frame model
module tb_serial_shift_arbiter;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [W-1:0] req_data0 = '0, req_data1 = '0;
    logic [1:0] req_ready;
    logic serial_out, frame_active, frame_last, grant_id;
    logic rst8 = 1'b1;
    logic [1:0] v8 = 2'b00;
    logic [7:0] d8_0 = '0, d8_1 = '0;
    logic [1:0] r8;
    logic s8, fa8, fl8, g8;
    int n_chk = 0, n_pass = 0;
    bit mq[$];
    logic m_ptr = 1'b0, m_gid = 1'b0;
    logic [1:0] obs_ready;
    logic obs_ser, obs_act, obs_last, obs_gid;

    always #5 clk = ~clk;

    serial_shift_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(req_ready), .serial_out(serial_out), .frame_active(frame_active),
        .frame_last(frame_last), .grant_id(grant_id)
    );

    serial_shift_arbiter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .req_valid(v8), .req_data0(d8_0), .req_data1(d8_1),
        .req_ready(r8), .serial_out(s8), .frame_active(fa8), .frame_last(fl8), .grant_id(g8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // one clock cycle: compare against the model, then advance the model on the edge
    task automatic cycle();
        logic w;
        logic [1:0] er;
        logic [W-1:0] dat;
        #1;
        w  = (req_valid == 2'b11) ? m_ptr : req_valid[1];
        er = (rst || mq.size() != 0 || req_valid == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
        check("req_ready", 32'(req_ready), 32'(er));
        check("serial_out", 32'(serial_out), mq.size() != 0 ? 32'(mq[0]) : 32'd0);
        check("frame_active", 32'(frame_active), 32'(mq.size() != 0));
        check("frame_last", 32'(frame_last), 32'(mq.size() == 1));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        obs_ready = req_ready;
        obs_ser   = serial_out;
        obs_act   = frame_active;
        obs_last  = frame_last;
        obs_gid   = grant_id;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ptr = 1'b0;
            m_gid = 1'b0;
        end else if (mq.size() != 0) begin
            void'(mq.pop_front());
        end else if (er != 2'b00) begin
            dat = w ? req_data1 : req_data0;
            for (int i = W - 1; i >= 0; i--) mq.push_back(dat[i]);
            m_gid = w;
            m_ptr = ~w;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] pat;
        logic [7:0] pat8;
        int hs_at;
        @(posedge clk);
        @(negedge clk);
        // reset state, reset beats a pending request
        req_valid = 2'b11;
        cycle();
        check("rst_ready", 32'(obs_ready), 32'd0);
        check("rst_serial", 32'(obs_ser), 32'd0);
        // single request 1011
        rst = 1'b0;
        req_valid = 2'b01;
        req_data0 = 4'b1011;
        pat = 4'b1011;
        cycle();
        check("single_ready", 32'(obs_ready), 32'h1);
        req_valid = 2'b00;
        for (int k = 0; k < W; k++) begin
            cycle();
            check("single_bit", 32'(obs_ser), 32'(pat[W-1-k]));
            check("single_last", 32'(obs_last), 32'(k == W - 1));
        end
        check("single_gid", 32'(obs_gid), 32'd0);
        cycle();
        // back-pressure: requester 0 raised mid-frame waits for the first IDLE cycle
        req_valid = 2'b10;
        req_data1 = 4'hF;
        cycle();
        check("bp_hs", 32'(obs_ready), 32'h2);
        req_valid = 2'b00;
        cycle();
        cycle();
        req_valid = 2'b01;
        req_data0 = 4'h3;
        hs_at = -1;
        for (int k = 3; k <= W + 1; k++) begin
            cycle();
            if (hs_at < 0 && obs_ready != 2'b00) hs_at = k;
        end
        check("bp_delay", 32'(hs_at), 32'(W + 1));
        req_valid = 2'b00;
        for (int k = 0; k < W + 1; k++) cycle();
        // mid-frame reset on 1100 after the second bit
        req_valid = 2'b01;
        req_data0 = 4'b1100;
        cycle();
        req_valid = 2'b00;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req_valid = 2'b11;
        req_data0 = 4'hA;
        req_data1 = 4'h5;
        cycle();
        check("abort_serial", 32'(obs_ser), 32'd0);
        check("abort_active", 32'(obs_act), 32'd0);
        check("abort_ptr", 32'(obs_ready), 32'h1);
        // contention alternates while both are held
        hs_at = 0;
        for (int k = 0; k < 4 * (W + 1); k++) begin
            cycle();
            if (obs_ready != 2'b00) hs_at++;
        end
        check("contend_grants", 32'(hs_at), 32'd4);
        // lone requester 1 repeats every W+1 cycles
        req_valid = 2'b10;
        req_data1 = 4'hF;
        for (int k = 0; k < 3 * (W + 1); k++) cycle();
        // randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            cycle();
            if (!req_valid[0] || obs_ready[0]) begin
                req_valid[0] = 1'($urandom_range(0, 1));
                req_data0 = W'($urandom);
            end else if ($urandom_range(0, 15) == 0) req_valid[0] = 1'b0;
            if (!req_valid[1] || obs_ready[1]) begin
                req_valid[1] = 1'($urandom_range(0, 1));
                req_data1 = W'($urandom);
            end else if ($urandom_range(0, 15) == 0) req_valid[1] = 1'b0;
        end
        rst = 1'b0;
        req_valid = 2'b00;
        cycle();
        // WIDTH=8 build: 81 frame, next handshake exactly 9 cycles later
        rst8 = 1'b0;
        v8 = 2'b01;
        d8_0 = 8'h81;
        pat8 = 8'h81;
        #1;
        check("w8_ready", 32'(r8), 32'h1);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            #1;
            check("w8_bit", 32'(s8), 32'(pat8[7-k]));
            check("w8_last", 32'(fl8), 32'(k == 7));
            check("w8_busy", 32'(r8), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("w8_gap", 32'(s8), 32'd0);
        check("w8_period", 32'(r8), 32'h1);
        check("w8_gid", 32'(g8), 32'd0);
        v8 = 2'b00;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
